// File: rtl/rt_mem_readback.sv
// Port-B readback engine: streams words from [base, base+4*n) with their addresses and sums them.
// Optional macro RT_READBACK_TIMEOUT_EN adds a per-request rvalid timeout and the sticky error_o flag.
module rt_mem_readback #(
  parameter int ADDR_WIDTH     = 22,
  parameter int DATA_WIDTH     = 32,
  parameter int FIFO_DEPTH     = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    start_i,
  input  logic [ADDR_WIDTH-1:0]   base_addr_i,
  input  logic [ADDR_WIDTH-2:0]   num_words_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    error_o,
  output logic [DATA_WIDTH-1:0]   checksum_o,
  output logic                    en_b_o,
  output logic                    we_b_o,
  output logic [DATA_WIDTH/8-1:0] be_b_o,
  output logic [ADDR_WIDTH-1:0]   addr_b_o,
  input  logic [DATA_WIDTH-1:0]   rdata_b_i,
  input  logic                    rvalid_b_i,
  output logic                    dout_valid_o,
  input  logic                    dout_ready_i,
  output logic [DATA_WIDTH-1:0]   dout_data_o,
  output logic [ADDR_WIDTH-1:0]   dout_addr_o
);
  localparam int PW = $clog2(FIFO_DEPTH);

  if (FIFO_DEPTH < 2 || (1 << PW) != FIFO_DEPTH || DATA_WIDTH != 32 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("rt_mem_readback: unsupported parameter set");
  end

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DRAIN, S_DONE} state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-2:0] r_rem;
  logic [DATA_WIDTH-1:0] r_sum;

  logic [DATA_WIDTH-1:0] r_fd [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] r_fa [FIFO_DEPTH];
  logic [PW-1:0]         r_wp, r_rp;
  logic [PW:0]           r_cnt;

  logic w_push, w_pop, w_full, w_tmo;

  assign w_full = r_cnt[PW];
  assign w_push = (r_state == S_WAIT) && rvalid_b_i;
  assign w_pop  = (r_cnt != '0) && dout_ready_i;

`ifdef RT_READBACK_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_tmo;
  logic          r_err;

  assign w_tmo   = (r_state == S_WAIT) && !rvalid_b_i && (r_tmo == TW'(TIMEOUT_CYCLES - 1));
  assign error_o = r_err;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_tmo <= '0;
      r_err <= 1'b0;
    end else begin
      r_tmo <= (r_state != S_WAIT || rvalid_b_i) ? '0 : r_tmo + 1'b1;
      if (r_state == S_IDLE && start_i) r_err <= 1'b0;
      else if (w_tmo)                   r_err <= 1'b1;
    end
  end
`else
  assign w_tmo   = 1'b0;
  assign error_o = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_rem   <= '0;
      r_sum   <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (start_i) begin
          r_addr  <= {base_addr_i[ADDR_WIDTH-1:2], 2'b00};
          r_rem   <= num_words_i;
          r_sum   <= '0;
          r_state <= (num_words_i == '0) ? S_DONE : S_REQ;
        end
        // The slot for this request is reserved here; pops during WAIT only free more.
        S_REQ: if (!w_full) r_state <= S_WAIT;
        S_WAIT: if (w_push) begin
          r_sum   <= r_sum + rdata_b_i;
          r_addr  <= r_addr + ADDR_WIDTH'(4);
          r_rem   <= r_rem - 1'b1;
          r_state <= (r_rem == (ADDR_WIDTH-1)'(1)) ? S_DRAIN : S_REQ;
        end else if (w_tmo) begin
          r_state <= S_DONE;
        end
        S_DRAIN: if (r_cnt == '0) r_state <= S_DONE;
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else if (w_tmo) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      r_cnt <= r_cnt + (PW+1)'(w_push) - (PW+1)'(w_pop);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_fd[i] <= '0;
        r_fa[i] <= '0;
      end
    end else if (w_push) begin
      r_fd[r_wp] <= rdata_b_i;
      r_fa[r_wp] <= r_addr;
    end
  end

  assign en_b_o       = (r_state == S_REQ) && !w_full;
  assign we_b_o       = 1'b0;
  assign be_b_o       = '1;
  assign addr_b_o     = r_addr;
  assign busy_o       = (r_state != S_IDLE);
  assign done_o       = (r_state == S_DONE);
  assign checksum_o   = r_sum;
  assign dout_valid_o = (r_cnt != '0);
  assign dout_data_o  = r_fd[r_rp];
  assign dout_addr_o  = r_fa[r_rp];
endmodule
